// File: rtl/sr_pkg.sv
// Shared types and constants for the round-robin ShiftReg arbiter.
package sr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } sr_state_t;

  localparam int WAIT_MAX_DEFAULT = 15;
  localparam int PULSE_WIDTH      = 1;

  // Index width that stays legal even for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping.
module rr_pick
  import sr_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IW    = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             valid,
  output logic [IW-1:0]    idx
);

  logic [IW-1:0] cand;

  // Scan from farthest to nearest so the closest candidate after ptr wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = IW'((int'(ptr) + i) % N_REQ);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/sr_arbiter.sv
// Round-robin arbiter sharing one 74HC595 ShiftReg driver between N_REQ byte producers.
module sr_arbiter
  import sr_pkg::*;
#(
  parameter  int N_REQ    = 4,
  parameter  int DW       = 8,
  parameter  int WAIT_MAX = WAIT_MAX_DEFAULT,
  localparam int IW       = idx_width(N_REQ)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [N_REQ-1:0]    i_req,
  input  logic [N_REQ*DW-1:0] i_data,
  output logic [N_REQ-1:0]    o_ack,
  output logic                o_err,
  output logic [IW-1:0]       o_grant,
  output logic                o_busy,
  output logic [DW-1:0]       o_data,
  output logic                o_en,
  input  logic                i_rdy
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  sr_state_t        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic [DW-1:0]    data_q, data_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             err_q, err_d;

  logic             pick_valid;
  logic [IW-1:0]    pick_idx;
  logic [DW-1:0]    pick_data;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (i_req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    pick_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick_idx == IW'(k)) pick_data = i_data[k*DW +: DW];
    end
  end

  // Grants wait for the driver to be idle, which also guards against a
  // transfer still running across a reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    ack_d   = '0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_rdy && pick_valid) begin
          grant_d = pick_idx;
          data_d  = pick_data;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!i_rdy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CW'(WAIT_MAX - 1)) begin
          err_d   = 1'b1;
          ptr_d   = grant_q;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (i_rdy) begin
          ack_d[grant_q] = 1'b1;
          ptr_d          = grant_q;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= IW'(N_REQ - 1);
      grant_q <= '0;
      data_q  <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign o_en    = (state_q == ST_LAUNCH);
  assign o_busy  = (state_q != ST_IDLE);
  assign o_ack   = ack_q;
  assign o_err   = err_q;
  assign o_grant = grant_q;
  assign o_data  = data_q;

endmodule

// File: tb/tb_sr_arbiter.sv
// Self-checking bench for sr_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model and a ShiftReg driver model.
module tb_sr_arbiter;

  localparam int N        = 4;
  localparam int DW       = 8;
  localparam int WMAX     = 15;
  localparam int BUSY_LEN = 18;

  logic            clk  = 1'b0;
  logic            rst  = 1'b0;
  logic [N-1:0]    req  = '0;
  logic [N*DW-1:0] data = '0;
  logic            rdy  = 1'b1;

  logic [N-1:0]    o_ack;
  logic            o_err;
  logic [1:0]      o_grant;
  logic            o_busy;
  logic [DW-1:0]   o_data;
  logic            o_en;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cycle        = 0;

  bit stuck     = 1'b0;
  bit rand_mode = 1'b0;
  int drv_left  = 0;

  int grant_log[$];
  int en_count = 0;
  int ack_total = 0;

  // model state
  bit            m_active = 1'b0;
  int            m_age    = 0;
  int            m_j      = 0;
  bit            m_seen_low = 1'b0;
  int            m_win    = 0;
  int            m_ptr    = N - 1;
  logic          exp_en   = 1'b0;
  logic          exp_busy = 1'b0;
  logic          exp_err  = 1'b0;
  logic [N-1:0]  exp_ack  = '0;
  logic [1:0]    exp_grant = '0;
  logic [DW-1:0] exp_data = '0;

  sr_arbiter #(.N_REQ(N), .DW(DW), .WAIT_MAX(WMAX)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_req   (req),
    .i_data  (data),
    .o_ack   (o_ack),
    .o_err   (o_err),
    .o_grant (o_grant),
    .o_busy  (o_busy),
    .o_data  (o_data),
    .o_en    (o_en),
    .i_rdy   (rdy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic int first_after(input logic [N-1:0] r, input int p);
    for (int i = 1; i <= N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return 0;
  endfunction

  // ShiftReg model: accepts on enable while ready, then busy for a fixed or random length.
  always @(posedge clk) begin
    if (rdy && o_en) begin
      if (!(stuck || (rand_mode && $urandom_range(0, 7) == 0))) begin
        rdy      <= 1'b0;
        drv_left <= rand_mode ? int'($urandom_range(1, 20)) : BUSY_LEN;
      end
    end else if (!rdy) begin
      if (drv_left <= 1) rdy <= 1'b1;
      else drv_left <= drv_left - 1;
    end
  end

  // Transaction-level reference: ages a transfer in cycles since its launch.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active  = 1'b0;
      m_ptr     = N - 1;
      exp_en    = 1'b0;
      exp_ack   = '0;
      exp_err   = 1'b0;
      exp_busy  = 1'b0;
      exp_grant = '0;
      exp_data  = '0;
    end else begin
      exp_en  = 1'b0;
      exp_ack = '0;
      exp_err = 1'b0;
      if (!m_active) begin
        if (rdy && req != '0) begin
          m_win      = first_after(req, m_ptr);
          exp_grant  = 2'(m_win);
          exp_data   = data[m_win*DW +: DW];
          m_active   = 1'b1;
          m_age      = 0;
          m_seen_low = 1'b0;
          exp_en     = 1'b1;
        end
      end else begin
        m_j   = m_age;
        m_age = m_age + 1;
        if (m_j >= 1) begin
          if (!m_seen_low) begin
            if (!rdy) m_seen_low = 1'b1;
            else if (m_j == WMAX) begin
              exp_err  = 1'b1;
              m_ptr    = m_win;
              m_active = 1'b0;
            end
          end else if (rdy) begin
            exp_ack[m_win] = 1'b1;
            m_ptr          = m_win;
            m_active       = 1'b0;
          end
        end
      end
      exp_busy = m_active;
    end
  end

  always @(negedge clk) begin
    check_output("en",    32'(o_en),    32'(exp_en));
    check_output("busy",  32'(o_busy),  32'(exp_busy));
    check_output("ack",   32'(o_ack),   32'(exp_ack));
    check_output("err",   32'(o_err),   32'(exp_err));
    check_output("grant", 32'(o_grant), 32'(exp_grant));
    check_output("data",  32'(o_data),  32'(exp_data));
  end

  always @(negedge clk) begin
    if (o_en) begin
      en_count++;
      grant_log.push_back(int'(o_grant));
    end
    if (o_ack != '0) ack_total++;
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_en(input int budget, input string name, output bit found, output int at);
    found = 1'b0;
    at    = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (o_en) begin
        found = 1'b1;
        at    = cycle;
        return;
      end
    end
    n_compared++;
    n_mismatched++;
    $display("[TB] FAIL %s: no o_en within %0d cycles, required one", name, budget);
  endtask

  task automatic wait_done(input int budget, input string name,
                           output logic [N-1:0] ack_v, output logic err_v, output int at);
    ack_v = '0;
    err_v = 1'b0;
    at    = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (o_ack != '0 || o_err) begin
        ack_v = o_ack;
        err_v = o_err;
        at    = cycle;
        return;
      end
    end
    n_compared++;
    n_mismatched++;
    $display("[TB] FAIL %s: no o_ack/o_err within %0d cycles, required one", name, budget);
  endtask

  task automatic check_log(input string name, input int exp_q[$]);
    check_output({name, "_count"}, 32'(grant_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check_output(name, (i < grant_log.size()) ? 32'(grant_log[i]) : 32'hFFFF, 32'(exp_q[i]));
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : apply_stimulus
    bit            found;
    int            c_en, c_done, n;
    logic [N-1:0]  ack_v;
    logic          err_v;
    int            exp_order[$];

    // reset values
    #1 rst = 1'b1;
    #1;
    check_output("rst_busy",  32'(o_busy),  32'h0);
    check_output("rst_en",    32'(o_en),    32'h0);
    check_output("rst_ack",   32'(o_ack),   32'h0);
    check_output("rst_err",   32'(o_err),   32'h0);
    check_output("rst_grant", 32'(o_grant), 32'h0);
    check_output("rst_data",  32'(o_data),  32'h0);

    // single requester
    @(negedge clk);
    rst  = 1'b0;
    req  = 4'b0001;
    data = 32'h1234_56A5;
    en_count = 0;
    wait_en(10, "t1_en", found, c_en);
    check_output("t1_grant", 32'(o_grant), 32'h0);
    check_output("t1_data",  32'(o_data),  32'hA5);
    wait_done(40, "t1_done", ack_v, err_v, c_done);
    check_output("t1_ack",      32'(ack_v),  32'h1);
    check_output("t1_err",      32'(err_v),  32'h0);
    check_output("t1_ack_data", 32'(o_data), 32'hA5);
    check_output("t1_busy_ack", 32'(o_busy), 32'h0);
    req = '0;
    repeat (3) @(negedge clk);
    check_output("t1_en_count", 32'(en_count), 32'h1);
    check_output("t1_busy_end", 32'(o_busy),   32'h0);

    // simultaneous requests 1 and 2
    apply_reset();
    grant_log.delete();
    req  = 4'b0110;
    data = $urandom();
    for (int i = 0; i < 4; i++) begin
      wait_done(60, "t2_done", ack_v, err_v, c_done);
      check_output("t2_ack", 32'(ack_v), (i % 2 == 0) ? 32'h2 : 32'h4);
    end
    req = '0;
    exp_order = '{1, 2, 1, 2};
    check_log("t2_order", exp_order);

    // all four held for eight transfers
    apply_reset();
    grant_log.delete();
    en_count = 0;
    req  = 4'b1111;
    data = $urandom();
    for (int i = 0; i < 8; i++) begin
      wait_done(60, "t3_done", ack_v, err_v, c_done);
      check_output("t3_ack", 32'(ack_v), 32'(1 << (i % 4)));
    end
    req = '0;
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
    check_log("t3_order", exp_order);
    check_output("t3_en_count", 32'(en_count), 32'h8);

    // stuck driver: timeout then the next requester is served
    apply_reset();
    stuck = 1'b1;
    req   = 4'b0011;
    wait_en(10, "t4_en", found, c_en);
    check_output("t4_grant", 32'(o_grant), 32'h0);
    wait_done(40, "t4_done", ack_v, err_v, c_done);
    check_output("t4_err",   32'(err_v), 32'h1);
    check_output("t4_ack",   32'(ack_v), 32'h0);
    check_output("t4_delay", 32'(c_done - c_en), 32'd16);
    stuck = 1'b0;
    wait_en(5, "t4_en2", found, c_en);
    check_output("t4_grant2", 32'(o_grant), 32'h1);
    wait_done(40, "t4_done2", ack_v, err_v, c_done);
    check_output("t4_ack2", 32'(ack_v), 32'h2);
    req = '0;

    // request dropped and data changed after launch
    apply_reset();
    req  = 4'b0100;
    data = 32'h003C_0000;
    wait_en(10, "t5_en", found, c_en);
    check_output("t5_data", 32'(o_data), 32'h3C);
    req  = '0;
    data = '0;
    wait_done(40, "t5_done", ack_v, err_v, c_done);
    check_output("t5_ack",      32'(ack_v),  32'h4);
    check_output("t5_held_data", 32'(o_data), 32'h3C);

    // asynchronous reset while waiting for the driver to finish
    apply_reset();
    req  = 4'b1000;
    data = 32'h7700_0000;
    wait_en(10, "t6_en", found, c_en);
    check_output("t6_grant", 32'(o_grant), 32'h3);
    n = 0;
    while (rdy && n < 5) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check_output("t6_busy_pre", 32'(o_busy), 32'h1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_output("t6_async_busy",  32'(o_busy),  32'h0);
    check_output("t6_async_en",    32'(o_en),    32'h0);
    check_output("t6_async_grant", 32'(o_grant), 32'h0);
    check_output("t6_async_data",  32'(o_data),  32'h0);
    @(negedge clk);
    rst  = 1'b0;
    req  = 4'b1001;
    data = 32'h7700_0011;
    check_output("t6_rdy_low", 32'(rdy), 32'h0);
    n = 0;
    while (!rdy && n < 40) begin
      check_output("t6_no_en", 32'(o_en), 32'h0);
      @(negedge clk);
      n++;
    end
    check_output("t6_rdy_back", 32'(rdy), 32'h1);
    wait_en(5, "t6_en2", found, c_en);
    check_output("t6_grant2", 32'(o_grant), 32'h0);
    wait_done(40, "t6_done", ack_v, err_v, c_done);
    check_output("t6_ack", 32'(ack_v), 32'h1);
    req = '0;

    // randomized traffic against the model
    apply_reset();
    rand_mode = 1'b1;
    ack_total = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req[$urandom_range(0, N-1)] ^= 1'b1;
      if ($urandom_range(0, 3) == 0) data = $urandom();
    end
    req = '0;
    n = 0;
    while ((o_busy || !rdy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_output("rand_idle", 32'(o_busy), 32'h0);
    check_output("rand_acked", 32'(ack_total > 0), 32'h1);
    rand_mode = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
